// File: rtl/omsp_hmac_sponge_adapter.sv
// omsp_hmac_sponge_adapter
// Bridges the HMAC control FSM (16-bit words, strobe/busy) to a byte-wide
// sponge hash core. Words are absorbed as bytes, big-endian. Finalization
// sends one tagged padding byte. Digest bytes are then squeezed back into
// 16-bit words.
//
// Handshake semantics (both directions): a byte moves on a rising clk edge
// exactly when valid and ready are both 1 in that cycle. While valid is high
// and ready is low, the sender holds its data and tags stable.
module omsp_hmac_sponge_adapter #(
  parameter logic [7:0] PAD_BYTE = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hmac_reset,
  input  logic        start_continue,
  input  logic        data_available,
  input  logic        data_is_long,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic [15:0] hmac_out,
  output logic        proto_err,
  output logic        core_clear,
  output logic [7:0]  core_in,
  output logic        core_in_valid,
  output logic        core_in_last,
  input  logic        core_in_ready,
  input  logic [7:0]  core_out,
  input  logic        core_out_valid,
  output logic        core_out_ready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_HI = 3'd1,
    ABS_LO = 3'd2,
    PAD    = 3'd3,
    SQZ_HI = 3'd4,
    SQZ_LO = 3'd5
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        sq;
  logic [15:0] word;
  logic [7:0]  hi;
  logic        clr;
  logic        cmd_err;
  logic        absorb_cmd;
  logic        final_cmd;

  assign clr        = reset | hmac_reset;
  assign core_clear = clr;
  assign dbg_state  = state;

  // Control samples busy in its strobe cycle, so the strobe itself counts.
  assign busy = (state != IDLE) | start_continue;

  // Accepted commands in IDLE; absorbing after finalization is illegal.
  assign absorb_cmd = (state == IDLE) & start_continue & data_available & ~sq;
  assign final_cmd  = (state == IDLE) & start_continue & ~data_available & ~sq;
  assign cmd_err    = start_continue & ((state != IDLE) | (data_available & sq));

  // Next-state and handshake outputs; all handshakes are forced low while clearing.
  always_comb begin
    next_state     = state;
    core_in        = 8'h00;
    core_in_valid  = 1'b0;
    core_in_last   = 1'b0;
    core_out_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start_continue) begin
          if (data_available && !sq) begin
            next_state = data_is_long ? ABS_HI : ABS_LO;
          end else if (!data_available) begin
            next_state = sq ? SQZ_HI : PAD;
          end
        end
      end
      ABS_HI: begin
        core_in       = word[15:8];
        core_in_valid = 1'b1;
        if (core_in_ready) next_state = ABS_LO;
      end
      ABS_LO: begin
        core_in       = word[7:0];
        core_in_valid = 1'b1;
        if (core_in_ready) next_state = IDLE;
      end
      PAD: begin
        core_in       = PAD_BYTE;
        core_in_valid = 1'b1;
        core_in_last  = 1'b1;
        if (core_in_ready) next_state = SQZ_HI;
      end
      SQZ_HI: begin
        core_out_ready = 1'b1;
        if (core_out_valid) next_state = SQZ_LO;
      end
      SQZ_LO: begin
        core_out_ready = 1'b1;
        if (core_out_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (clr) begin
      next_state     = IDLE;
      core_in        = 8'h00;
      core_in_valid  = 1'b0;
      core_in_last   = 1'b0;
      core_out_ready = 1'b0;
    end
  end

  // State, phase, data capture and sticky error flag.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      sq        <= 1'b0;
      word      <= 16'h0000;
      hi        <= 8'h00;
      hmac_out  <= 16'h0000;
      proto_err <= 1'b0;
    end else begin
      state <= next_state;
      if (absorb_cmd) word <= data_in;
      if (final_cmd) sq <= 1'b1;
      if (state == SQZ_HI && core_out_valid) hi <= core_out;
      if (state == SQZ_LO && core_out_valid) hmac_out <= {hi, core_out};
      if (cmd_err) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_omsp_hmac_sponge_adapter.sv
// Directed bench for omsp_hmac_sponge_adapter: absorb, pad, squeeze,
// backpressure, protocol errors and mid-transfer clear.
module tb_omsp_hmac_sponge_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hmac_reset;
  logic        start_continue;
  logic        data_available;
  logic        data_is_long;
  logic [15:0] data_in;
  logic        busy;
  logic [15:0] hmac_out;
  logic        proto_err;
  logic        core_clear;
  logic [7:0]  core_in;
  logic        core_in_valid;
  logic        core_in_last;
  logic        core_in_ready;
  logic [7:0]  core_out;
  logic        core_out_valid;
  logic        core_out_ready;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected bytes into the core, tagged {last, byte}.
  logic [8:0] exp_q[$];

  // Digest byte source standing in for the core.
  logic [7:0] src [8];
  int src_idx = 0;
  assign core_out = (src_idx < 8) ? src[src_idx] : 8'h00;

  omsp_hmac_sponge_adapter #(.PAD_BYTE(8'h80)) dut (
    .clk            (clk),
    .reset          (reset),
    .hmac_reset     (hmac_reset),
    .start_continue (start_continue),
    .data_available (data_available),
    .data_is_long   (data_is_long),
    .data_in        (data_in),
    .busy           (busy),
    .hmac_out       (hmac_out),
    .proto_err      (proto_err),
    .core_clear     (core_clear),
    .core_in        (core_in),
    .core_in_valid  (core_in_valid),
    .core_in_last   (core_in_last),
    .core_in_ready  (core_in_ready),
    .core_out       (core_out),
    .core_out_valid (core_out_valid),
    .core_out_ready (core_out_ready),
    .dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every byte accepted by the core must match the expected queue.
  always @(posedge clk) begin
    logic [8:0] e;
    if (core_in_valid && core_in_ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
      check("core_byte", {7'b0, core_in_last, core_in}, {7'b0, e});
    end
    if (core_out_valid && core_out_ready) src_idx <= src_idx + 1;
  end

  initial begin
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
    src[4] = 8'h55; src[5] = 8'h66; src[6] = 8'h77; src[7] = 8'h88;
    reset = 1'b1; hmac_reset = 1'b0; start_continue = 1'b0;
    data_available = 1'b0; data_is_long = 1'b0; data_in = 16'h0;
    core_in_ready = 1'b0; core_out_valid = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_clear", {15'b0, core_clear}, 16'd1);
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_valid", {15'b0, core_in_valid}, 16'd0);
    check("rst_oready", {15'b0, core_out_ready}, 16'd0);
    check("rst_hmac", hmac_out, 16'h0000);
    check("rst_err", {15'b0, proto_err}, 16'd0);
    check("rst_state", {13'b0, dbg_state}, 16'd0);
    reset = 1'b0;
    #1 check("clear_low", {15'b0, core_clear}, 16'd0);

    // Long absorb A1B2, core always ready
    start_continue = 1'b1; data_available = 1'b1; data_is_long = 1'b1;
    data_in = 16'hA1B2; core_in_ready = 1'b1;
    exp_q.push_back(9'h0A1); exp_q.push_back(9'h0B2);
    #1 check("long_busy_t0", {15'b0, busy}, 16'd1);
    tick(); start_continue = 1'b0;
    #1 check("long_state1", {13'b0, dbg_state}, 16'd1);
    check("long_hi", {8'b0, core_in}, 16'h00A1);
    check("long_valid", {15'b0, core_in_valid}, 16'd1);
    check("long_last", {15'b0, core_in_last}, 16'd0);
    check("long_busy_t1", {15'b0, busy}, 16'd1);
    tick();
    #1 check("long_lo", {8'b0, core_in}, 16'h00B2);
    check("long_busy_t2", {15'b0, busy}, 16'd1);
    tick();
    #1 check("long_busy_t3", {15'b0, busy}, 16'd0);
    check("long_idle_valid", {15'b0, core_in_valid}, 16'd0);

    // Short absorb 0001
    start_continue = 1'b1; data_is_long = 1'b0; data_in = 16'h0001;
    exp_q.push_back(9'h001);
    #1 check("short_busy_t0", {15'b0, busy}, 16'd1);
    tick(); start_continue = 1'b0;
    #1 check("short_state", {13'b0, dbg_state}, 16'd2);
    check("short_byte", {8'b0, core_in}, 16'h0001);
    check("short_last", {15'b0, core_in_last}, 16'd0);
    tick();
    #1 check("short_busy_t2", {15'b0, busy}, 16'd0);

    // Backpressure in ABS_HI, plus a strobe while busy
    core_in_ready = 1'b0; start_continue = 1'b1; data_is_long = 1'b1; data_in = 16'hC3D4;
    exp_q.push_back(9'h0C3); exp_q.push_back(9'h0D4);
    tick(); start_continue = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_byte", {8'b0, core_in}, 16'h00C3);
      check("bp_valid", {15'b0, core_in_valid}, 16'd1);
      check("bp_busy", {15'b0, busy}, 16'd1);
      tick();
    end
    start_continue = 1'b1; data_in = 16'hFFFF;
    tick(); start_continue = 1'b0;
    #1 check("busy_strobe_err", {15'b0, proto_err}, 16'd1);
    check("busy_strobe_state", {13'b0, dbg_state}, 16'd1);
    check("busy_strobe_byte", {8'b0, core_in}, 16'h00C3);
    core_in_ready = 1'b1;
    tick();
    #1 check("bp_resume_lo", {8'b0, core_in}, 16'h00D4);
    tick();
    #1 check("bp_done_busy", {15'b0, busy}, 16'd0);
    hmac_reset = 1'b1;
    #1 check("hrst_clear", {15'b0, core_clear}, 16'd1);
    tick(); hmac_reset = 1'b0;
    #1 check("hrst_err", {15'b0, proto_err}, 16'd0);

    // Finalize: pad byte then first digest word
    core_out_valid = 1'b1; start_continue = 1'b1; data_available = 1'b0;
    exp_q.push_back(9'h180);
    tick(); start_continue = 1'b0;
    #1 check("pad_state", {13'b0, dbg_state}, 16'd3);
    check("pad_byte", {8'b0, core_in}, 16'h0080);
    check("pad_last", {15'b0, core_in_last}, 16'd1);
    check("pad_oready", {15'b0, core_out_ready}, 16'd0);
    tick();
    #1 check("sqz_hi_state", {13'b0, dbg_state}, 16'd4);
    check("sqz_hi_oready", {15'b0, core_out_ready}, 16'd1);
    check("sqz_hi_ivalid", {15'b0, core_in_valid}, 16'd0);
    tick();
    #1 check("sqz_lo_state", {13'b0, dbg_state}, 16'd5);
    tick();
    #1 check("digest0", hmac_out, 16'h1122);
    check("digest0_busy", {15'b0, busy}, 16'd0);

    // Second squeeze; hmac_out holds until completion
    start_continue = 1'b1;
    tick(); start_continue = 1'b0;
    tick();
    #1 check("digest_hold", hmac_out, 16'h1122);
    tick();
    #1 check("digest1", hmac_out, 16'h3344);

    // Absorb after finalization is a protocol error
    start_continue = 1'b1; data_available = 1'b1; data_in = 16'h1234;
    tick(); start_continue = 1'b0; data_available = 1'b0;
    #1 check("sq_abs_err", {15'b0, proto_err}, 16'd1);
    check("sq_abs_state", {13'b0, dbg_state}, 16'd0);
    check("sq_abs_valid", {15'b0, core_in_valid}, 16'd0);

    // Third squeeze
    start_continue = 1'b1;
    tick(); start_continue = 1'b0;
    tick(); tick();
    #1 check("digest2", hmac_out, 16'h5566);

    // Clear in the middle of SQZ_LO
    start_continue = 1'b1;
    tick(); start_continue = 1'b0;
    tick();
    hmac_reset = 1'b1;
    #1 check("mid_clear", {15'b0, core_clear}, 16'd1);
    check("mid_oready", {15'b0, core_out_ready}, 16'd0);
    tick(); hmac_reset = 1'b0;
    #1 check("mid_state", {13'b0, dbg_state}, 16'd0);
    check("mid_hmac", hmac_out, 16'h0000);
    check("mid_err", {15'b0, proto_err}, 16'd0);
    check("mid_src", src_idx[15:0], 16'd7);

    // Phase cleared: absorbing is legal again
    core_out_valid = 1'b0;
    start_continue = 1'b1; data_available = 1'b1; data_is_long = 1'b0; data_in = 16'h005A;
    exp_q.push_back(9'h05A);
    tick(); start_continue = 1'b0; data_available = 1'b0;
    #1 check("post_byte", {8'b0, core_in}, 16'h005A);
    tick();
    #1 check("post_err", {15'b0, proto_err}, 16'd0);
    check("post_busy", {15'b0, busy}, 16'd0);

    check("exp_q_empty", exp_q.size(), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
